// File: rtl/card_slot_fetch_scheduler.sv
// card_slot_fetch_scheduler
//   Once per frame, this block fetches the card index of every on-screen slot
//   from the shared data RAM. The fetches go into per-slot shadow registers.
//   When the whole sweep has succeeded, the shadow registers are copied into
//   the active registers in a single cycle. The VGA pixel path reads the active
//   registers combinationally, so a frame never shows a mix of old and new
//   cards.
// Ports
//   clk, reset  system clock; asynchronous active-high reset
//   screenEnd   one-cycle frame-boundary pulse; starts a sweep when idle
//   slotSel     slot currently being drawn
//   cardIndex   committed card index of slotSel (0 when slotSel >= NUM_SLOTS)
//   memReq      read request to the RAM arbiter
//   memAddr     read word address of the request
//   memGnt      arbiter grant for the current request
//   memData     read data
//   memValid    read data valid
//   validMask   committed per-slot "holds a legal card" flags
//   busy        a sweep is in progress
//   frameDone   one-cycle pulse when a sweep commits
//   fetchErr    one-cycle pulse on a timeout abort or a frame overrun

// One slot: a shadow register that is filled during the sweep, and an active
// register that is loaded from the shadow on commit.
module card_slot_reg (
   input  logic        clk,
   input  logic        reset,
   input  logic        wr,
   input  logic        commit,
   input  logic [31:0] data,
   input  logic        legal,
   output logic [31:0] active,
   output logic        active_ok
);
   logic [31:0] shadow;
   logic        shadow_ok;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shadow    <= '0;
         shadow_ok <= 1'b0;
         active    <= '0;
         active_ok <= 1'b0;
      end else begin
         // Illegal indices are stored as an empty slot.
         if (wr) begin
            shadow    <= legal ? data : '0;
            shadow_ok <= legal;
         end
         if (commit) begin
            active    <= shadow;
            active_ok <= shadow_ok;
         end
      end
   end
endmodule

module card_slot_fetch_scheduler #(
   parameter int NUM_SLOTS = 7,
   parameter int BASE_ADDR = 16,
   parameter int MAX_CARD  = 13,
   parameter int TIMEOUT   = 255
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 screenEnd,
   input  logic [2:0]           slotSel,
   output logic [31:0]          cardIndex,
   output logic                 memReq,
   output logic [31:0]          memAddr,
   input  logic                 memGnt,
   input  logic [31:0]          memData,
   input  logic                 memValid,
   output logic [NUM_SLOTS-1:0] validMask,
   output logic                 busy,
   output logic                 frameDone,
   output logic                 fetchErr
);
   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {IDLE, REQ, WAIT, COMMIT, ABORT} state_t;

   state_t          state;
   logic [2:0]      slot;
   logic [TW-1:0]   timer;
   logic            rd_ok;
   logic            legal;
   logic            last;
   logic [NUM_SLOTS-1:0][31:0] active;

   assign rd_ok = (state == WAIT) && memValid;
   // The full 32-bit value is compared, so large garbage words are not legal.
   assign legal = (memData != 32'd0) && (memData <= 32'(MAX_CARD));
   assign last  = (slot == 3'(NUM_SLOTS - 1));
   assign busy  = (state != IDLE);

   genvar i;
   generate
      for (i = 0; i < NUM_SLOTS; i++) begin : g_slot
         card_slot_reg u_slot (
            .clk       (clk),
            .reset     (reset),
            .wr        (rd_ok && (slot == 3'(i))),
            .commit    (state == COMMIT),
            .data      (memData),
            .legal     (legal),
            .active    (active[i]),
            .active_ok (validMask[i])
         );
      end
   endgenerate

   // This mux has zero latency so that it stays aligned with the pixel pipeline.
   always_comb begin
      cardIndex = '0;
      for (int s = 0; s < NUM_SLOTS; s++)
         if (slotSel == 3'(s)) cardIndex = active[s];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         slot      <= '0;
         timer     <= '0;
         memReq    <= 1'b0;
         memAddr   <= 32'(BASE_ADDR);
         frameDone <= 1'b0;
         fetchErr  <= 1'b0;
      end else begin
         frameDone <= 1'b0;
         // A frame boundary that arrives during a sweep, including the COMMIT
         // and ABORT cycles, is an overrun. It is ORed with the abort
         // condition below, so the pulse stays one cycle wide.
         fetchErr  <= screenEnd && (state != IDLE);
         case (state)
            IDLE: if (screenEnd) begin
               slot    <= '0;
               memReq  <= 1'b1;
               memAddr <= 32'(BASE_ADDR);
               state   <= REQ;
            end
            // memReq and memAddr hold their values until the grant arrives.
            REQ: if (memGnt) begin
               memReq <= 1'b0;
               timer  <= '0;
               state  <= WAIT;
            end
            WAIT: begin
               if (memValid) begin
                  if (last) begin
                     frameDone <= 1'b1;
                     state     <= COMMIT;
                  end else begin
                     slot    <= slot + 3'd1;
                     memReq  <= 1'b1;
                     memAddr <= 32'(BASE_ADDR) + 32'(slot) + 32'd1;
                     state   <= REQ;
                  end
               end else if (timer == TW'(TIMEOUT - 1)) begin
                  // TIMEOUT WAIT cycles have passed with no data.
                  fetchErr <= 1'b1;
                  state    <= ABORT;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            COMMIT:  state <= IDLE;
            ABORT:   state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule
